// File: rtl/cs_sched_pkg.sv
// Shared types and defaults for the mission-clock transfer scheduler.
//   state_e   : scheduler FSM states (idle, request outstanding, done, fatal error)
//   ch_t      : channel index as carried on xfer_ch_o
//   UPLOAD_CH : the one channel whose transfer is a put (SUT word uploaded)
package cs_sched_pkg;

    localparam int unsigned DEFAULT_NCH = 4;
    localparam int unsigned DEFAULT_DW  = 9;
    localparam int unsigned DEFAULT_TMO = 1024;
    localparam int unsigned UPLOAD_CH   = 3;
    localparam int unsigned CH_W        = 2;

    typedef logic [CH_W-1:0] ch_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone,
        StErr
    } state_e;

    function automatic logic is_upload(ch_t ch);
        return ch == ch_t'(UPLOAD_CH);
    endfunction

endpackage

// File: rtl/cs_rr_arb.sv
// Round-robin channel picker.
//   req   : pending-request vector, one bit per channel
//   last  : channel served most recently; search starts at last+1 (mod NCH)
//   grant : index of the first requesting channel found
//   any   : at least one request present (grant is meaningless otherwise)
module cs_rr_arb
    import cs_sched_pkg::*;
#(
    parameter int unsigned NCH = DEFAULT_NCH
) (
    input  logic [NCH-1:0] req,
    input  ch_t            last,
    output ch_t            grant,
    output logic           any
);

    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

    int unsigned idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        // i = NCH wraps back to 'last' itself, so it is considered last.
        for (int unsigned i = 1; i <= NCH; i++) begin
            idx = (32'(last) + i) % NCH;
            if (!any && req[idx[IW-1:0]]) begin
                any   = 1'b1;
                grant = ch_t'(idx);
            end
        end
    end

endmodule

// File: rtl/trgt_xfer_sched.sv
// Transfer scheduler between mission-clock channels and the shunt transport.
// Each channel edge request freezes that channel's mission clock until one
// transport transaction for it has completed. Channels 0..2 download a word
// (get), channel 3 uploads the SUT output word (put).
//   clk_i, rst_ni  : utility clock, synchronous active-low reset
//   edge_req_i     : per-channel one-cycle request pulses
//   sut_data_i     : word uploaded on the upload channel, sampled at grant
//   freeze_clk_o   : per-channel mission-clock hold (all ones once in error)
//   xfer_*         : transport request/response handshake
//   rx_valid_o/rx_data_o : one-cycle delivery of a downloaded word
//   ovf_o, err_o   : sticky overrun flags and sticky fatal error
module trgt_xfer_sched
    import cs_sched_pkg::*;
#(
    parameter int unsigned NCH = DEFAULT_NCH,
    parameter int unsigned DW  = DEFAULT_DW,
    parameter int unsigned TMO = DEFAULT_TMO
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [NCH-1:0] edge_req_i,
    input  logic [DW-1:0]  sut_data_i,
    output logic [NCH-1:0] freeze_clk_o,
    output logic           xfer_req_o,
    output logic [1:0]     xfer_ch_o,
    output logic           xfer_dir_o,
    output logic [DW-1:0]  xfer_wdata_o,
    input  logic           xfer_ack_i,
    input  logic           xfer_err_i,
    input  logic [DW-1:0]  xfer_rdata_i,
    output logic [2:0]     rx_valid_o,
    output logic [DW-1:0]  rx_data_o,
    output logic [NCH-1:0] ovf_o,
    output logic           err_o
);

    localparam int unsigned   CW       = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

    state_e         state_q, state_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] ovf_q, ovf_d;
    ch_t            last_q, last_d;
    ch_t            ch_q, ch_d;
    logic           dir_q, dir_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0] clr;

    ch_t  arb_grant;
    logic arb_any;

    cs_rr_arb #(
        .NCH (NCH)
    ) u_arb (
        .req   (pend_q),
        .last  (last_q),
        .grant (arb_grant),
        .any   (arb_any)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        ch_d    = ch_q;
        dir_d   = dir_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        clr     = '0;

        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    ch_d    = arb_grant;
                    dir_d   = is_upload(arb_grant);
                    wdata_d = sut_data_i;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                cnt_d = cnt_q + 1'b1;
                // Error (or timeout) outranks a simultaneous ack.
                if (xfer_err_i || cnt_q == CNT_LAST) begin
                    state_d = StErr;
                end else if (xfer_ack_i) begin
                    rdata_d = xfer_rdata_i;
                    state_d = StDone;
                end
            end
            StDone: begin
                clr     = NCH'(1) << ch_q;
                last_d  = ch_q;
                state_d = StIdle;
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StErr;
            end
        endcase

        // A new edge on the channel being retired re-arms it and is not an overrun.
        pend_d = (pend_q & ~clr) | edge_req_i;
        ovf_d  = ovf_q | (edge_req_i & pend_q & ~clr);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            pend_q  <= '0;
            ovf_q   <= '0;
            last_q  <= ch_t'(NCH - 1);
            ch_q    <= '0;
            dir_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
            dir_q   <= dir_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        rx_valid_o = '0;
        rx_data_o  = '0;
        if (state_q == StDone && !dir_q) begin
            rx_valid_o = 3'b001 << ch_q;
            rx_data_o  = rdata_q;
        end
    end

    assign freeze_clk_o = (state_q == StErr) ? {NCH{1'b1}} : pend_q;
    assign xfer_req_o   = (state_q == StReq);
    assign err_o        = (state_q == StErr);
    assign xfer_ch_o    = ch_q;
    assign xfer_dir_o   = dir_q;
    assign xfer_wdata_o = wdata_q;
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_trgt_xfer_sched.sv
module tb_trgt_xfer_sched;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 9;
    localparam int unsigned TMO = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] ed;
    logic [DW-1:0]  sut;
    logic [NCH-1:0] freeze;
    logic           req;
    logic [1:0]     ch;
    logic           dir;
    logic [DW-1:0]  wdata;
    logic           ack;
    logic           xerr;
    logic [DW-1:0]  rdata;
    logic [2:0]     rxv;
    logic [DW-1:0]  rxd;
    logic [NCH-1:0] ovf;
    logic           errf;

    int checks = 0;
    int errors = 0;

    trgt_xfer_sched #(
        .NCH (NCH),
        .DW  (DW),
        .TMO (TMO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .edge_req_i   (ed),
        .sut_data_i   (sut),
        .freeze_clk_o (freeze),
        .xfer_req_o   (req),
        .xfer_ch_o    (ch),
        .xfer_dir_o   (dir),
        .xfer_wdata_o (wdata),
        .xfer_ack_i   (ack),
        .xfer_err_i   (xerr),
        .xfer_rdata_i (rdata),
        .rx_valid_o   (rxv),
        .rx_data_o    (rxd),
        .ovf_o        (ovf),
        .err_o        (errf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] ed;
        logic       ack;
        logic [8:0] rd;
        logic       e_req;
        logic [1:0] e_ch;
        logic [2:0] e_rxv;
        logic [8:0] e_rxd;
        logic [3:0] e_frz;
        logic [3:0] e_ovf;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic [3:0] e, logic a, logic [8:0] r, logic q, logic [1:0] c,
                                logic [2:0] v, logic [8:0] d, logic [3:0] f, logic [3:0] o);
        vec_t x;
        x.ed = e; x.ack = a; x.rd = r; x.e_req = q; x.e_ch = c;
        x.e_rxv = v; x.e_rxd = d; x.e_frz = f; x.e_ovf = o;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ed    = '0;
        ack   = 1'b0;
        xerr  = 1'b0;
        rdata = '0;
        sut   = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (req !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("wait_req", 32'(req), 32'd1);
    endtask

    // Round-robin choice from the rule: first pending channel after 'last'.
    function automatic int rr_pick(logic [3:0] p, int last);
        for (int i = 1; i <= 4; i++) begin
            int k = (last + i) % 4;
            if (p[k]) return k;
        end
        return -1;
    endfunction

    task automatic run_vectors();
        vecs[0]  = mk(4'b0001, 0, 9'h000, 0, 0, 3'b000, 9'h000, 4'b0000, 4'b0000);
        vecs[1]  = mk(4'b0000, 0, 9'h000, 0, 0, 3'b000, 9'h000, 4'b0001, 4'b0000);
        vecs[2]  = mk(4'b0000, 0, 9'h000, 1, 0, 3'b000, 9'h000, 4'b0001, 4'b0000);
        vecs[3]  = mk(4'b0000, 0, 9'h000, 1, 0, 3'b000, 9'h000, 4'b0001, 4'b0000);
        vecs[4]  = mk(4'b0000, 1, 9'h1A5, 1, 0, 3'b000, 9'h000, 4'b0001, 4'b0000);
        vecs[5]  = mk(4'b0000, 0, 9'h0FF, 0, 0, 3'b001, 9'h1A5, 4'b0001, 4'b0000);
        vecs[6]  = mk(4'b0000, 0, 9'h000, 0, 0, 3'b000, 9'h000, 4'b0000, 4'b0000);
        vecs[7]  = mk(4'b0010, 0, 9'h000, 0, 0, 3'b000, 9'h000, 4'b0000, 4'b0000);
        vecs[8]  = mk(4'b0010, 0, 9'h000, 0, 0, 3'b000, 9'h000, 4'b0010, 4'b0000);
        vecs[9]  = mk(4'b0000, 1, 9'h055, 1, 1, 3'b000, 9'h000, 4'b0010, 4'b0010);
        vecs[10] = mk(4'b0000, 0, 9'h000, 0, 0, 3'b010, 9'h055, 4'b0010, 4'b0010);
        vecs[11] = mk(4'b0000, 0, 9'h000, 0, 0, 3'b000, 9'h000, 4'b0000, 4'b0010);
        vecs[12] = mk(4'b0000, 0, 9'h000, 0, 0, 3'b000, 9'h000, 4'b0000, 4'b0010);
        vecs[13] = mk(4'b0000, 0, 9'h000, 0, 0, 3'b000, 9'h000, 4'b0000, 4'b0010);

        do_reset();
        chk("reset_outputs", {freeze, req, ch, dir, wdata, rxv, rxd, ovf, errf}, 32'd0);
        for (int i = 0; i < 14; i++) begin
            ed    = vecs[i].ed;
            ack   = vecs[i].ack;
            rdata = vecs[i].rd;
            chk($sformatf("vec%0d.req", i), 32'(req), 32'(vecs[i].e_req));
            chk($sformatf("vec%0d.freeze", i), 32'(freeze), 32'(vecs[i].e_frz));
            chk($sformatf("vec%0d.ovf", i), 32'(ovf), 32'(vecs[i].e_ovf));
            chk($sformatf("vec%0d.rx_valid", i), 32'(rxv), 32'(vecs[i].e_rxv));
            chk($sformatf("vec%0d.err", i), 32'(errf), 32'd0);
            if (vecs[i].e_req) begin
                chk($sformatf("vec%0d.ch", i), 32'(ch), 32'(vecs[i].e_ch));
                chk($sformatf("vec%0d.dir", i), 32'(dir), 32'(vecs[i].e_ch == 2'd3));
            end
            if (vecs[i].e_rxv != 3'b000)
                chk($sformatf("vec%0d.rx_data", i), 32'(rxd), 32'(vecs[i].e_rxd));
            step();
        end
        ed = '0; ack = 1'b0;
    endtask

    task automatic seq_all_channels();
        int         order[$];
        logic [8:0] last_sut;
        do_reset();
        last_sut = 9'($urandom);
        sut = last_sut;
        ed  = 4'hF;
        step();
        ed = '0;
        for (int c = 0; c < 60 && order.size() < 4; c++) begin
            if (req) begin
                order.push_back(int'(ch));
                chk("rr.dir", 32'(dir), 32'(ch == 2'd3));
                if (ch == 2'd3) chk("rr.upload_wdata", 32'(wdata), 32'(last_sut));
            end
            ack      = req;
            rdata    = 9'($urandom);
            last_sut = 9'($urandom);
            sut      = last_sut;
            step();
        end
        ack = 1'b0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr.order%0d", i), 32'(order.size() > i ? order[i] : 99), 32'(i));
    endtask

    task automatic seq_done_reedge();
        do_reset();
        ed = 4'b0100;
        step();
        ed = '0;
        wait_req(10);
        ack = 1'b1; rdata = 9'h13C;
        step();
        ack = 1'b0;
        chk("reedge.rx_valid", 32'(rxv), 32'b100);
        ed = 4'b0100;
        step();
        ed = '0;
        chk("reedge.freeze", 32'(freeze), 32'b0100);
        chk("reedge.ovf", 32'(ovf), 32'd0);
        wait_req(10);
        chk("reedge.ch", 32'(ch), 32'd2);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        step();
        chk("reedge.freeze_clear", 32'(freeze), 32'd0);
    endtask

    task automatic seq_ack_err();
        do_reset();
        ed = 4'b0100;
        step();
        ed = '0;
        wait_req(10);
        ack = 1'b1; xerr = 1'b1; rdata = 9'h0AA;
        step();
        ack = 1'b0; xerr = 1'b0;
        chk("ackerr.err", 32'(errf), 32'd1);
        chk("ackerr.rx_valid", 32'(rxv), 32'd0);
        chk("ackerr.req", 32'(req), 32'd0);
        chk("ackerr.freeze", 32'(freeze), 32'hF);
        ed = 4'b0001;
        step();
        ed = '0;
        step();
        step();
        chk("ackerr.sticky", {27'd0, errf, req, rxv}, {27'd0, 1'b1, 1'b0, 3'b000});
    endtask

    task automatic seq_timeout();
        do_reset();
        ed = 4'b0001;
        step();
        ed = '0;
        wait_req(10);
        repeat (TMO - 1) step();
        chk("tmo.still_req", 32'(req), 32'd1);
        chk("tmo.not_err_yet", 32'(errf), 32'd0);
        step();
        chk("tmo.err", 32'(errf), 32'd1);
        chk("tmo.req_dropped", 32'(req), 32'd0);
        chk("tmo.freeze", 32'(freeze), 32'hF);
        ed = 4'b0010;
        step();
        ed = '0;
        repeat (5) step();
        chk("tmo.no_grant", {30'd0, req, errf}, {30'd0, 1'b0, 1'b1});
    endtask

    task automatic seq_reset_mid();
        do_reset();
        sut = 9'h1F0;
        ed  = 4'b1000;
        step();
        ed = '0;
        wait_req(10);
        rst_n = 1'b0; ack = 1'b1; rdata = 9'h077;
        step();
        rst_n = 1'b1; ack = 1'b0;
        chk("rstmid.outputs", {freeze, req, ch, dir, wdata, rxv, rxd, ovf, errf}, 32'd0);
        step();
        chk("rstmid.no_rx", 32'(rxv), 32'd0);
        ed = 4'b0100;
        step();
        ed = '0;
        step();
        chk("rstmid.req_t2", 32'(req), 32'd1);
        chk("rstmid.ch", 32'(ch), 32'd2);
        ack = 1'b1; rdata = 9'h123;
        step();
        ack = 1'b0;
        chk("rstmid.rx_valid", 32'(rxv), 32'b100);
        chk("rstmid.rx_data", 32'(rxd), 32'h123);
    endtask

    // Transaction-level reference: a grant opens a request window that ends at
    // the ack the bench chooses; delivery follows one cycle later and the
    // channel becomes grantable again one cycle after that.
    task automatic run_random(input int ncyc);
        logic [3:0] m_pend, m_ovf, clr;
        logic [2:0] e_rxv;
        logic [8:0] exp_wd, exp_rd;
        int m_last, free_at, req_lo, req_hi, rx_at, cur_ch;
        bit in_req;
        do_reset();
        m_pend = '0; m_ovf = '0; m_last = 3; free_at = 0;
        req_lo = -10; req_hi = -10; rx_at = -10; cur_ch = 0;
        exp_wd = '0; exp_rd = '0;
        for (int n = 0; n < ncyc; n++) begin
            in_req = (n >= req_lo) && (n <= req_hi);
            chk("rnd.freeze", 32'(freeze), 32'(m_pend));
            chk("rnd.ovf", 32'(ovf), 32'(m_ovf));
            chk("rnd.req", 32'(req), 32'(in_req));
            chk("rnd.err", 32'(errf), 32'd0);
            if (in_req) begin
                chk("rnd.ch", 32'(ch), 32'(cur_ch));
                chk("rnd.dir", 32'(dir), 32'(cur_ch == 3));
                if (cur_ch == 3) chk("rnd.wdata", 32'(wdata), 32'(exp_wd));
            end
            e_rxv = '0;
            if (n == rx_at && cur_ch < 3) e_rxv[cur_ch] = 1'b1;
            chk("rnd.rx_valid", 32'(rxv), 32'(e_rxv));
            if (e_rxv != 3'b000) chk("rnd.rx_data", 32'(rxd), 32'(exp_rd));

            for (int k = 0; k < 4; k++) ed[k] = ($urandom_range(0, 9) == 0);
            sut   = 9'($urandom);
            ack   = (n == req_hi);
            rdata = ack ? exp_rd : 9'($urandom);

            clr = '0;
            if (n == rx_at) begin
                clr[cur_ch] = 1'b1;
                m_last = cur_ch;
            end
            if (n >= free_at && m_pend != 4'b0000) begin
                cur_ch  = rr_pick(m_pend, m_last);
                req_lo  = n + 1;
                req_hi  = n + 1 + int'($urandom_range(0, 4));
                rx_at   = req_hi + 1;
                free_at = req_hi + 2;
                exp_wd  = sut;
                exp_rd  = 9'($urandom);
            end
            m_ovf  = m_ovf | (ed & m_pend & ~clr);
            m_pend = (m_pend & ~clr) | ed;
            step();
        end
        ed = '0; ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ed = '0; sut = '0; ack = 1'b0; xerr = 1'b0; rdata = '0;
        run_vectors();
        seq_all_channels();
        seq_done_reedge();
        seq_ack_err();
        seq_timeout();
        seq_reset_mid();
        run_random(3000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trgt_xfer_sched.md
TRGT_XFER_SCHED -- requirements
Module: trgt_xfer_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of mission-clock channels; channels 0..2 download, channel 3 uploads.
REQ-002 SHALL have parameter DW, default 9, meaning transfer word width {valid/wen, data[7:0]}.
REQ-003 SHALL have parameter TMO, default 1024, meaning clk_i cycles allowed per transfer before timeout.
REQ-004 SHALL have one clock and a synchronous, active-low reset, as listed below.
REQ-005 clk_i  in  1  utility clock; all logic on rising edge.
REQ-006 rst_ni  in  1  synchronous active-low reset.
REQ-007 edge_req_i  in  NCH  one-cycle pulse per channel: mission-clock edge seen, transfer needed.
REQ-008 sut_data_i  in  DW  SUT output word, uploaded on channel 3.
REQ-009 freeze_clk_o  out  NCH  per-channel mission-clock hold.
REQ-010 xfer_req_o  out  1  transport request to shunt layer.
REQ-011 xfer_ch_o  out  2  channel being served.
REQ-012 xfer_dir_o  out  1  0 = get (download), 1 = put (upload).
REQ-013 xfer_wdata_o  out  DW  upload word.
REQ-014 xfer_ack_i  in  1  transport done; xfer_rdata_i valid this cycle.
REQ-015 xfer_err_i  in  1  transport failure, sampled only while xfer_req_o=1.
REQ-016 xfer_rdata_i  in  DW  downloaded word.
REQ-017 rx_valid_o  out  3  one-cycle pulse, one-hot, downloaded word for channel k.
REQ-018 rx_data_o  out  DW  downloaded word, valid with rx_valid_o.
REQ-019 ovf_o  out  NCH  sticky per-channel overrun flag.
REQ-020 err_o  out  1  sticky fatal error (transport error or timeout).

Function
REQ-021 SHALL keep pend_q[NCH-1:0]; edge_req_i[k] at cycle t sets pend_q[k] at t+1.
REQ-022 freeze_clk_o SHALL equal pend_q (registered), asserted from t+1 until the cycle after service completes.
REQ-023 FSM states SHALL be IDLE, REQ, DONE, ERR.
REQ-024 IDLE: if any pend_q set, SHALL grant round-robin starting at last_q+1 (mod NCH), latch ch, dir = (ch==3), wdata = sut_data_i, go REQ; else stay.
REQ-025 REQ: xfer_req_o=1, xfer_ch_o/xfer_dir_o/xfer_wdata_o held stable; xfer_ack_i -> DONE; xfer_err_i or timeout counter == TMO-1 -> ERR.
REQ-026 ack and err in same cycle SHALL be treated as err.
REQ-027 DONE (one cycle): clear pend_q[ch], last_q = ch, for ch<3 pulse rx_valid_o[ch] with rx_data_o = word captured at ack; -> IDLE.
REQ-028 Minimum latency: edge_req_i at t, idle FSM -> xfer_req_o at t+2; ack at u -> rx_valid_o at u+1, freeze_clk_o[ch] low at u+2.
REQ-029 edge_req_i[k] while pend_q[k]=1 SHALL set ovf_o[k]; request not double-queued.
REQ-030 edge_req_i[ch] in the DONE cycle of ch SHALL re-set pend_q[ch] (set wins over clear), no overflow.
REQ-031 Timeout counter SHALL clear on entry to REQ and count each REQ cycle.
REQ-032 ERR: err_o=1, xfer_req_o=0, freeze_clk_o all ones, no further grants; exit only by reset.

Reset
REQ-033 rst_ni=0 at a clock edge SHALL force IDLE, pend_q=0, last_q=NCH-1 (channel 0 first), counter=0, all outputs 0, including mid-transfer (request dropped, no rx pulse).

Structure
REQ-034 State enum, channel index type, DW/TMO defaults and UPLOAD_CH=3 SHALL live in shared package cs_sched_pkg.
REQ-035 Round-robin picker SHALL be sub-module cs_rr_arb (request vector + last pointer -> grant index + any).

Verification
REQ-036 edge_req_i=0001 at t, ack at t+4 with rdata=0x1A5 -> xfer_req_o t+2..t+4, ch=0, dir=0, rx_valid_o=001 and rx_data_o=0x1A5 at t+5, freeze_clk_o[0] low at t+6.
REQ-037 edge_req_i=1111 same cycle, immediate acks -> service order 0,1,2,3; channel 3 put carries sut_data_i sampled at its grant, dir=1.
REQ-038 Second edge_req_i[1] while ch1 pending -> ovf_o=0010 sticky, exactly one ch1 transfer.
REQ-039 No ack for TMO cycles -> err_o=1 at REQ cycle TMO+1, freeze_clk_o=1111, xfer_req_o=0 thereafter.
REQ-040 xfer_err_i and xfer_ack_i together -> ERR, no rx_valid_o pulse.
REQ-041 rst_ni low during REQ -> next cycle all outputs 0, no rx pulse; fresh edge_req_i served normally.
